// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and sizing for the RAM entry controller
package ram_ctrl_pkg;

   localparam int ADDR_W_DEF     = 4;
   localparam int DATA_W_DEF     = 8;
   localparam int REPEAT_DLY_DEF = 25_000_000;
   localparam int REPEAT_PER_DEF = 5_000_000;

   // Write mode is WR_IDLE/WR_COMMIT, read mode is RD_IDLE.
   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      RD_IDLE   = 2'd2
   } state_e;

   // Counter width that can hold the larger of the two repeat intervals.
   function automatic int rep_cnt_w(input int dly, input int per);
      int m;
      m = (dly > per) ? dly : per;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

   localparam int REPEAT_CNT_W = rep_cnt_w(REPEAT_DLY_DEF, REPEAT_PER_DEF);

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button press detector with optional hold auto-repeat (HOLD_REPEAT_EN)
module btn_edge
   import ram_ctrl_pkg::*;
#(
   parameter int REPEAT_DLY = REPEAT_DLY_DEF,
   parameter int REPEAT_PER = REPEAT_PER_DEF
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] btn_i,
   output logic [1:0] press_o
);

   logic [1:0] btn_q;
   logic [1:0] edge_w;

   // Previous button levels; all ones at reset so a held button gives no press.
   always_ff @(posedge clk) begin
      if (clr) btn_q <= 2'b11;
      else     btn_q <= btn_i;
   end

   assign edge_w = btn_i & ~btn_q;

`ifdef HOLD_REPEAT_EN
   localparam int CNT_W = rep_cnt_w(REPEAT_DLY, REPEAT_PER);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             rep_q, rep_d;
   logic             fire;
   logic             held;

   // btn[0] was high last cycle and still is: the hold is continuing.
   assign held    = btn_i[0] & btn_q[0];
   assign cnt_inc = cnt_q + 1'b1;

   // Count held cycles; first repeat after REPEAT_DLY, later ones every REPEAT_PER.
   always_comb begin
      cnt_d = cnt_q;
      rep_d = rep_q;
      fire  = 1'b0;
      if (!held || edge_w[1]) begin
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (cnt_inc == (rep_q ? CNT_W'(REPEAT_PER) : CNT_W'(REPEAT_DLY))) begin
         fire  = 1'b1;
         cnt_d = '0;
         rep_d = 1'b1;
      end else begin
         cnt_d = cnt_inc;
      end
   end

   // Repeat counter state.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end
   end

   assign press_o = edge_w | {1'b0, fire};
`else
   assign press_o = edge_w;
`endif

endmodule

// File: rtl/ram_entry_ctrl.sv
// rtl/ram_entry_ctrl.sv - write/read mode FSM over a 16x8 RAM (HOLD_REPEAT_EN enables auto-repeat)
module ram_entry_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REPEAT_DLY = REPEAT_DLY_DEF,
   parameter int REPEAT_PER = REPEAT_PER_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [1:0]        btn,
   input  logic [DATA_W-1:0] sw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dout,
   output logic              we,
   output logic              mode,
   output logic              wrap
);

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q;
   logic              wrap_q, wrap_d;
   logic [1:0]        press;
   logic [DATA_W-1:0] mem [DEPTH];

   btn_edge #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_btn_edge (
      .clk     (clk),
      .clr     (clr),
      .btn_i   (btn),
      .press_o (press)
   );

   // Next state, address and wrap flag; a mode change outranks a store/step.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wrap_d  = 1'b0;
      case (state_q)
         WR_IDLE: begin
            if (press[1]) begin
               state_d = RD_IDLE;
               addr_d  = '0;
            end else if (press[0]) begin
               state_d = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            addr_d  = addr_q + 1'b1;
            wrap_d  = (addr_q == ADDR_MAX);
            state_d = WR_IDLE;
         end
         RD_IDLE: begin
            if (press[1]) begin
               state_d = WR_IDLE;
               addr_d  = '0;
            end else if (press[0]) begin
               addr_d = addr_q + 1'b1;
               wrap_d = (addr_q == ADDR_MAX);
            end
         end
         default: begin
            state_d = WR_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= WR_IDLE;
         addr_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wrap_q  <= wrap_d;
      end
   end

   // Memory write in the commit cycle; contents survive clr, and clr cancels the write.
   always_ff @(posedge clk) begin
      if (!clr && state_q == WR_COMMIT) mem[addr_q] <= sw;
   end

   // Registered read-first output of the current address.
   always_ff @(posedge clk) begin
      if (clr) dout_q <= '0;
      else     dout_q <= mem[addr_q];
   end

   assign addr = addr_q;
   assign dout = dout_q;
   assign we   = (state_q == WR_COMMIT);
   assign mode = (state_q == RD_IDLE);
   assign wrap = wrap_q;

endmodule

// File: tb/tb_ram_entry_ctrl.sv
// tb/tb_ram_entry_ctrl.sv - self-checking bench for ram_entry_ctrl
module tb_ram_entry_ctrl;

   logic       clk;
   logic       clr;
   logic [1:0] btn;
   logic [7:0] sw;
   logic [3:0] addr;
   logic [7:0] dout;
   logic       we;
   logic       mode;
   logic       wrap;

   int checks;
   int failures;

   // Reference model: user-visible behaviour of the entry panel.
   bit [1:0] m_btnq;
   bit       m_rd;
   bit       m_cm;
   bit [3:0] m_addr;
   bit [7:0] m_mem [16];
   bit       m_known [16];
   bit [7:0] m_dout;
   bit       m_dknown;
   bit       m_wrap;
   int       m_held;

   ram_entry_ctrl #(
      .ADDR_W     (4),
      .DATA_W     (8),
      .REPEAT_DLY (10),
      .REPEAT_PER (4)
   ) dut (
      .clk  (clk),
      .clr  (clr),
      .btn  (btn),
      .sw   (sw),
      .addr (addr),
      .dout (dout),
      .we   (we),
      .mode (mode),
      .wrap (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_update(input bit c, input bit [1:0] b, input bit [7:0] s);
      bit [1:0] pr;
      pr = b & ~m_btnq;
`ifdef HOLD_REPEAT_EN
      if (c || !(b[0] && m_btnq[0]) || pr[1]) m_held = 0;
      else begin
         m_held++;
         if (m_held == 10 || (m_held > 10 && (m_held - 10) % 4 == 0)) pr[0] = 1'b1;
      end
`endif
      if (c) begin
         m_btnq = 2'b11; m_rd = 0; m_cm = 0; m_addr = 0;
         m_dout = 0; m_dknown = 1; m_wrap = 0;
         return;
      end
      m_dout   = m_mem[m_addr];
      m_dknown = m_known[m_addr];
      m_wrap   = 0;
      if (m_cm) begin
         m_mem[m_addr]   = s;
         m_known[m_addr] = 1;
         m_wrap = (m_addr == 4'hF);
         m_addr = m_addr + 1;
         m_cm   = 0;
      end else if (pr[1]) begin
         m_rd   = !m_rd;
         m_addr = 0;
      end else if (pr[0]) begin
         if (m_rd) begin
            m_wrap = (m_addr == 4'hF);
            m_addr = m_addr + 1;
         end else begin
            m_cm = 1;
         end
      end
      m_btnq = b;
   endtask

   task automatic step(input bit c, input bit [1:0] b, input bit [7:0] s);
      clr = c; btn = b; sw = s;
      @(posedge clk);
      model_update(c, b, s);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(1, 2'b01, 8'h00);
      checks++; if (addr !== 4'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", addr); end
      checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout); end
      checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we); end
      checks++; if (mode !== 1'b0) begin failures++; $display("FAIL reset_mode got=%0b exp=0", mode); end
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
      for (int i = 0; i < 4; i++) begin
         step(0, 2'b01, 8'h00);
         checks++;
         if (we !== 1'b0 || addr !== 4'h0) begin
            failures++; $display("FAIL held_through_reset we=%0b addr=%0h exp we=0 addr=0", we, addr);
         end
      end
      step(0, 2'b00, 8'h00);
      step(0, 2'b01, 8'h00);
      checks++; if (we !== 1'b1) begin failures++; $display("FAIL repress_we got=%0b exp=1", we); end
      step(0, 2'b00, 8'h00);
      checks++; if (we !== 1'b0 || addr !== 4'h1) begin
         failures++; $display("FAIL repress_after we=%0b addr=%0h exp we=0 addr=1", we, addr);
      end
   endtask

   task automatic test_write_read();
      step(1, 2'b00, 8'h00);
      step(0, 2'b00, 8'hA5);
      step(0, 2'b01, 8'hA5);
      checks++; if (we !== 1'b1 || addr !== 4'h0) begin
         failures++; $display("FAIL wr_commit we=%0b addr=%0h exp we=1 addr=0", we, addr);
      end
      step(0, 2'b01, 8'hA5);
      checks++; if (we !== 1'b0 || addr !== 4'h1) begin
         failures++; $display("FAIL wr_single we=%0b addr=%0h exp we=0 addr=1", we, addr);
      end
      step(0, 2'b00, 8'h00);
      step(0, 2'b10, 8'h00);
      checks++; if (mode !== 1'b1 || addr !== 4'h0) begin
         failures++; $display("FAIL rd_enter mode=%0b addr=%0h exp mode=1 addr=0", mode, addr);
      end
      step(0, 2'b00, 8'h00);
      checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL rd_dout got=%0h exp=a5", dout); end
   endtask

   task automatic test_wrap();
      int nwrap;
      nwrap = 0;
      step(1, 2'b00, 8'h00);
      for (int i = 0; i < 16; i++) begin
         step(0, 2'b00, 8'(i));
         if (wrap === 1'b1) nwrap++;
         step(0, 2'b01, 8'(i));
         if (wrap === 1'b1) nwrap++;
         step(0, 2'b00, 8'(i));
         if (wrap === 1'b1) nwrap++;
         checks++; if (wrap !== m_wrap || addr !== m_addr) begin
            failures++; $display("FAIL wr_seq wrap=%0b addr=%0h exp wrap=%0b addr=%0h", wrap, addr, m_wrap, m_addr);
         end
      end
      checks++; if (nwrap != 1 || addr !== 4'h0) begin
         failures++; $display("FAIL wr_wrap pulses=%0d addr=%0h exp pulses=1 addr=0", nwrap, addr);
      end
      step(0, 2'b10, 8'h00);
      checks++; if (wrap !== 1'b0 || mode !== 1'b1) begin
         failures++; $display("FAIL mode_no_wrap wrap=%0b mode=%0b exp wrap=0 mode=1", wrap, mode);
      end
      step(0, 2'b00, 8'h00);
      checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rd_step0 got=%0h exp=0", dout); end
      for (int i = 1; i < 16; i++) begin
         step(0, 2'b01, 8'h00);
         checks++; if (addr !== 4'(i)) begin failures++; $display("FAIL rd_addr got=%0h exp=%0h", addr, i); end
         step(0, 2'b00, 8'h00);
         checks++; if (dout !== 8'(i)) begin failures++; $display("FAIL rd_step got=%0h exp=%0h", dout, i); end
      end
      step(0, 2'b01, 8'h00);
      checks++; if (wrap !== 1'b1 || addr !== 4'h0) begin
         failures++; $display("FAIL rd_wrap wrap=%0b addr=%0h exp wrap=1 addr=0", wrap, addr);
      end
      step(0, 2'b00, 8'h00);
      checks++; if (wrap !== 1'b0 || dout !== 8'h00) begin
         failures++; $display("FAIL rd_wrap_after wrap=%0b dout=%0h exp wrap=0 dout=0", wrap, dout);
      end
   endtask

   task automatic test_simultaneous();
      step(1, 2'b00, 8'h00);
      step(0, 2'b00, 8'h77);
      step(0, 2'b11, 8'h77);
      checks++; if (mode !== 1'b1 || addr !== 4'h0 || we !== 1'b0) begin
         failures++; $display("FAIL both_press mode=%0b addr=%0h we=%0b exp 1/0/0", mode, addr, we);
      end
      step(0, 2'b00, 8'h77);
      checks++; if (we !== 1'b0 || mode !== 1'b1) begin
         failures++; $display("FAIL both_after we=%0b mode=%0b exp we=0 mode=1", we, mode);
      end
   endtask

   task automatic test_clr_commit();
      step(1, 2'b00, 8'h00);
      step(0, 2'b00, 8'h5A);
      step(0, 2'b01, 8'h5A);
      step(0, 2'b00, 8'h5A);
      step(1, 2'b00, 8'h00);
      step(0, 2'b00, 8'h3C);
      step(0, 2'b01, 8'h3C);
      checks++; if (we !== 1'b1) begin failures++; $display("FAIL clr_pre_we got=%0b exp=1", we); end
      step(1, 2'b01, 8'h3C);
      checks++; if (addr !== 4'h0 || dout !== 8'h00 || we !== 1'b0 || mode !== 1'b0 || wrap !== 1'b0) begin
         failures++; $display("FAIL clr_outputs addr=%0h dout=%0h we=%0b mode=%0b wrap=%0b exp all 0", addr, dout, we, mode, wrap);
      end
      step(0, 2'b00, 8'h00);
      step(0, 2'b10, 8'h00);
      step(0, 2'b00, 8'h00);
      checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL clr_readback got=%0h exp=5a", dout); end
   endtask

   task automatic test_random();
      bit       c;
      bit [1:0] b;
      step(1, 2'b00, 8'h00);
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(0, 63) == 0);
         b = ($urandom_range(0, 2) == 0) ? 2'($urandom) : btn;
         step(c, b, 8'($urandom));
         checks++;
         if (addr !== m_addr || we !== m_cm || mode !== m_rd || wrap !== m_wrap ||
             (m_dknown && dout !== m_dout)) begin
            failures++;
            $display("FAIL random cyc=%0d addr=%0h we=%0b mode=%0b wrap=%0b dout=%0h exp addr=%0h we=%0b mode=%0b wrap=%0b dout=%0h",
                     i, addr, we, mode, wrap, dout, m_addr, m_cm, m_rd, m_wrap, m_dout);
         end
      end
   endtask

`ifdef HOLD_REPEAT_EN
   task automatic test_repeat();
      step(1, 2'b00, 8'h00);
      step(0, 2'b10, 8'h00);
      step(0, 2'b00, 8'h00);
      for (int i = 0; i < 30; i++) begin
         step(0, 2'b01, 8'h00);
         checks++; if (addr !== m_addr) begin
            failures++; $display("FAIL repeat_trace cyc=%0d got=%0h exp=%0h", i, addr, m_addr);
         end
      end
      step(0, 2'b00, 8'h00);
      checks++; if (addr !== 4'h6) begin failures++; $display("FAIL repeat_total got=%0h exp=6", addr); end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      m_held = 0;
      m_btnq = 2'b11;
      for (int i = 0; i < 16; i++) m_known[i] = 0;
      clr = 1'b1; btn = 2'b00; sw = 8'h00;
      #1;
      test_reset();
      test_write_read();
      test_wrap();
      test_simultaneous();
      test_clr_commit();
      test_random();
`ifdef HOLD_REPEAT_EN
      test_repeat();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
